mem_wb_pipe: RTL and testbench
==============================

// Module: mem_wb_pipe
// PURPOSE
//  Parametrised MEM->WB pipeline register with the write-back data select. Adds pipeline control: stall, flush, valid bit,
//  sub-word load extraction/extension, R0 write suppression, and a retired-instruction counter.
//  Sits between the memory stage and the register file write port; also drives the WB forwarding source.
// PARAMETERS
//  DATA_W   32  datapath width (aluR, mdata, dest); must be 32 when sub-word loads are used
//  REG_AW   5   register-file address width
//  TAG_W    4   width of ins_type / ins_number debug tags
//  CNT_W    16  width of retired-instruction counter
// PORTS
//  clk              in   1       clock, rising edge
//  rst              in   1       synchronous, active-high reset
//  mem_valid        in   1       MEM slot holds a real instruction
//  mem_wreg         in   1       instruction writes a register
//  mem_m2reg        in   1       1 = write-back data from memory, 0 = from ALU
//  mem_destR        in   REG_AW  destination register
//  mem_aluR         in   DATA_W  ALU result
//  mem_mdata        in   DATA_W  raw memory read word
//  mem_ld_size      in   2       00 byte, 01 half, 10/11 word
//  mem_ld_uns       in   1       1 = zero-extend, 0 = sign-extend
//  mem_byte_off     in   2       byte address bits [1:0] of load
//  MEM_ins_type     in   TAG_W   debug tag
//  MEM_ins_number   in   TAG_W   debug tag
//  wb_stall         in   1       hold WB register contents
//  wb_flush         in   1       load a bubble instead of the MEM slot
//  wb_valid         out  1       WB slot holds a real instruction
//  wb_wreg          out  1       register-file write enable (qualified)
//  wb_destR         out  REG_AW  write address
//  wb_dest          out  DATA_W  write data
//  WB_ins_type      out  TAG_W   registered debug tag
//  WB_ins_number    out  TAG_W   registered debug tag
//  wb_retired       out  CNT_W   count of valid instructions accepted into WB
// BEHAVIOUR
//  - Reset is synchronous and active-high; rst is sampled only on the rising edge of clk.
//  - On rst: every register clears to 0, so all outputs read 0 (wb_dest = 0, wb_retired = 0).
//  - Priority at each edge: rst > wb_flush > wb_stall > normal capture.
//  - Normal capture loads all mem_* fields and tags. Latency is 1 cycle from MEM inputs to WB outputs.
//  - Flush: valid, wreg, m2reg, destR and tags load 0. Data registers may load anything, because wb_wreg = 0 masks them.
//  - Flush with stall asserted in the same cycle: the flush is taken.
//  - Stall: every register, including the counter, holds its value. Outputs stay stable for as long as the stall lasts.
//  - wb_wreg = r_valid & r_wreg & (r_destR != 0). A write to R0 is never emitted; wb_dest still shows the data.
//  - wb_dest is combinational from registered state:
//      r_m2reg = 0: r_aluR.
//      r_m2reg = 1: the extracted load value.
//  - Load extraction works on registered r_mdata, little-endian:
//      byte: lane = off[1:0], bits [8*off+7 : 8*off].
//      half: lane = off[1], bits [16*off[1]+15 : 16*off[1]]; off[0] is ignored (misalign is trapped upstream).
//      word: full word; offset is ignored.
//      Extension: sign-extend from the lane MSB when ld_uns = 0, zero-extend when ld_uns = 1.
//  - wb_retired increments by 1 on every non-stalled, non-flushed, non-reset edge where mem_valid = 1.
//    It wraps modulo 2^CNT_W with no saturation.
//  - Reset mid-stall or mid-flush: reset wins; the next edge resumes normal capture.
// STRUCTURE
//  - Shared package holds the constants LD_BYTE = 2'b00, LD_HALF = 2'b01, LD_WORD = 2'b10.
//  - Sub-module load_extend (combinational): inputs mdata, size, off, uns; output ext_data.
//  - Top level holds the pipeline register, the control priority, the write-back mux and the counter.
// TESTING
//  1. Reset: hold rst for 2 cycles mid-traffic -> all outputs 0, including wb_retired = 0.
//  2. ALU pass: valid, wreg, m2reg = 0, destR = 3, aluR = 0x1234_5678 -> next cycle wb_wreg = 1, wb_destR = 3,
//     wb_dest = 0x1234_5678, wb_retired = 1.
//  3. Loads, all with mdata = 0x80FF_7F01:
//     byte signed, off = 3 -> 0xFFFF_FF80.
//     byte unsigned, off = 2 -> 0x0000_00FF.
//     half signed, off = 2 -> 0xFFFF_80FF.
//     half unsigned, off = 0 -> 0x0000_7F01.
//     word -> 0x80FF_7F01.
//  4. R0 write: valid, wreg, destR = 0 -> wb_wreg = 0, wb_valid = 1, counter increments.
//  5. Stall 3 cycles while MEM inputs change -> WB outputs and wb_retired unchanged; the first edge after release
//     captures the current MEM inputs.
//  6. Flush and stall asserted together with a valid MEM instruction -> wb_valid = 0, wb_wreg = 0, counter unchanged.
//     Separately: preload wb_retired = 2^CNT_W - 1, then one valid capture -> wb_retired = 0.

Source files
------------

// File: rtl/mem_wb_pipe_pkg.sv
// rtl/mem_wb_pipe_pkg.sv - shared load-size encodings for the MEM->WB stage
package mem_wb_pipe_pkg;
   localparam logic [1:0] LD_BYTE = 2'b00;
   localparam logic [1:0] LD_HALF = 2'b01;
   localparam logic [1:0] LD_WORD = 2'b10;
endpackage

// File: rtl/mem_wb_pipe_if.sv
// rtl/mem_wb_pipe_if.sv - MEM-stage slot bundle presented to the WB pipeline register
interface mem_wb_pipe_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int TAG_W  = 4
) ();
   logic              mem_valid;
   logic              mem_wreg;
   logic              mem_m2reg;
   logic [REG_AW-1:0] mem_destR;
   logic [DATA_W-1:0] mem_aluR;
   logic [DATA_W-1:0] mem_mdata;
   logic [1:0]        mem_ld_size;
   logic              mem_ld_uns;
   logic [1:0]        mem_byte_off;
   logic [TAG_W-1:0]  MEM_ins_type;
   logic [TAG_W-1:0]  MEM_ins_number;

   modport master (
      output mem_valid, mem_wreg, mem_m2reg, mem_destR, mem_aluR, mem_mdata,
             mem_ld_size, mem_ld_uns, mem_byte_off, MEM_ins_type, MEM_ins_number
   );
   modport slave (
      input  mem_valid, mem_wreg, mem_m2reg, mem_destR, mem_aluR, mem_mdata,
             mem_ld_size, mem_ld_uns, mem_byte_off, MEM_ins_type, MEM_ins_number
   );
endinterface

// File: rtl/mem_wb_pipe_load_extend.sv
// rtl/mem_wb_pipe_load_extend.sv - little-endian sub-word lane select with sign/zero extension
module load_extend
   import mem_wb_pipe_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] mdata,
   input  logic [1:0]        size,
   input  logic [1:0]        off,
   input  logic              uns,
   output logic [DATA_W-1:0] ext_data
);
   logic [DATA_W-1:0] byte_sh;
   logic [DATA_W-1:0] half_sh;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;

   always_comb begin
      byte_sh = mdata >> {off, 3'b000};
      // Halfword lane uses off[1] only; misaligned halves never reach this stage.
      half_sh = mdata >> {off[1], 4'b0000};
      lane_b  = byte_sh[7:0];
      lane_h  = half_sh[15:0];
      case (size)
         LD_BYTE: ext_data = {{(DATA_W-8){~uns & lane_b[7]}}, lane_b};
         LD_HALF: ext_data = {{(DATA_W-16){~uns & lane_h[15]}}, lane_h};
         default: ext_data = mdata;
      endcase
   end
endmodule

// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - MEM->WB pipeline register with stall/flush, load extraction and retire counter
module mem_wb_pipe
   import mem_wb_pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int TAG_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   mem_wb_pipe_if.slave      mem,
   input  logic              wb_stall,
   input  logic              wb_flush,
   output logic              wb_valid,
   output logic              wb_wreg,
   output logic [REG_AW-1:0] wb_destR,
   output logic [DATA_W-1:0] wb_dest,
   output logic [TAG_W-1:0]  WB_ins_type,
   output logic [TAG_W-1:0]  WB_ins_number,
   output logic [CNT_W-1:0]  wb_retired
);
   logic              valid_q,   valid_d;
   logic              wreg_q,    wreg_d;
   logic              m2reg_q,   m2reg_d;
   logic [REG_AW-1:0] destr_q,   destr_d;
   logic [DATA_W-1:0] alur_q,    alur_d;
   logic [DATA_W-1:0] mdata_q,   mdata_d;
   logic [1:0]        ld_size_q, ld_size_d;
   logic              ld_uns_q,  ld_uns_d;
   logic [1:0]        off_q,     off_d;
   logic [TAG_W-1:0]  type_q,    type_d;
   logic [TAG_W-1:0]  num_q,     num_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic [DATA_W-1:0] load_val;

   // Flush beats stall; data registers just hold on a flush since wreg=0 masks them.
   always_comb begin
      valid_d   = valid_q;
      wreg_d    = wreg_q;
      m2reg_d   = m2reg_q;
      destr_d   = destr_q;
      alur_d    = alur_q;
      mdata_d   = mdata_q;
      ld_size_d = ld_size_q;
      ld_uns_d  = ld_uns_q;
      off_d     = off_q;
      type_d    = type_q;
      num_d     = num_q;
      retired_d = retired_q;
      if (wb_flush) begin
         valid_d = 1'b0;
         wreg_d  = 1'b0;
         m2reg_d = 1'b0;
         destr_d = '0;
         type_d  = '0;
         num_d   = '0;
      end else if (!wb_stall) begin
         valid_d   = mem.mem_valid;
         wreg_d    = mem.mem_wreg;
         m2reg_d   = mem.mem_m2reg;
         destr_d   = mem.mem_destR;
         alur_d    = mem.mem_aluR;
         mdata_d   = mem.mem_mdata;
         ld_size_d = mem.mem_ld_size;
         ld_uns_d  = mem.mem_ld_uns;
         off_d     = mem.mem_byte_off;
         type_d    = mem.MEM_ins_type;
         num_d     = mem.MEM_ins_number;
         retired_d = retired_q + CNT_W'(mem.mem_valid);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         wreg_q    <= 1'b0;
         m2reg_q   <= 1'b0;
         destr_q   <= '0;
         alur_q    <= '0;
         mdata_q   <= '0;
         ld_size_q <= LD_BYTE;
         ld_uns_q  <= 1'b0;
         off_q     <= '0;
         type_q    <= '0;
         num_q     <= '0;
         retired_q <= '0;
      end else begin
         valid_q   <= valid_d;
         wreg_q    <= wreg_d;
         m2reg_q   <= m2reg_d;
         destr_q   <= destr_d;
         alur_q    <= alur_d;
         mdata_q   <= mdata_d;
         ld_size_q <= ld_size_d;
         ld_uns_q  <= ld_uns_d;
         off_q     <= off_d;
         type_q    <= type_d;
         num_q     <= num_d;
         retired_q <= retired_d;
      end
   end

   load_extend #(.DATA_W(DATA_W)) u_load_extend (
      .mdata    (mdata_q),
      .size     (ld_size_q),
      .off      (off_q),
      .uns      (ld_uns_q),
      .ext_data (load_val)
   );

   assign wb_valid      = valid_q;
   assign wb_wreg       = valid_q & wreg_q & (destr_q != '0);
   assign wb_destR      = destr_q;
   assign wb_dest       = m2reg_q ? load_val : alur_q;
   assign WB_ins_type   = type_q;
   assign WB_ins_number = num_q;
   assign wb_retired    = retired_q;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb/tb_mem_wb_pipe.sv - directed self-checking bench for mem_wb_pipe
module tb_mem_wb_pipe;
   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int TAG_W  = 4;
   localparam int CNT_W  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              wb_stall, wb_flush;
   logic              wb_valid, wb_wreg;
   logic [REG_AW-1:0] wb_destR;
   logic [DATA_W-1:0] wb_dest;
   logic [TAG_W-1:0]  WB_ins_type, WB_ins_number;
   logic [CNT_W-1:0]  wb_retired;

   int n_vec = 0;
   int n_err = 0;

   mem_wb_pipe_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .TAG_W(TAG_W)) mif ();

   mem_wb_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .mem           (mif.slave),
      .wb_stall      (wb_stall),
      .wb_flush      (wb_flush),
      .wb_valid      (wb_valid),
      .wb_wreg       (wb_wreg),
      .wb_destR      (wb_destR),
      .wb_dest       (wb_dest),
      .WB_ins_type   (WB_ins_type),
      .WB_ins_number (WB_ins_number),
      .wb_retired    (wb_retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mem(input logic v, input logic w, input logic m2r, input logic [4:0] d,
                          input logic [31:0] alu, input logic [31:0] md, input logic [1:0] sz,
                          input logic uns, input logic [1:0] off, input logic [3:0] ty,
                          input logic [3:0] num);
      mif.mem_valid      = v;
      mif.mem_wreg       = w;
      mif.mem_m2reg      = m2r;
      mif.mem_destR      = d;
      mif.mem_aluR       = alu;
      mif.mem_mdata      = md;
      mif.mem_ld_size    = sz;
      mif.mem_ld_uns     = uns;
      mif.mem_byte_off   = off;
      mif.MEM_ins_type   = ty;
      mif.MEM_ins_number = num;
   endtask

   task automatic load(input logic [1:0] sz, input logic uns, input logic [1:0] off,
                       input logic [31:0] exp, input logic [7:0] cnt, input string tag);
      set_mem(1, 1, 1, 5'd7, 32'h0, 32'h80FF_7F01, sz, uns, off, 4'h1, 4'h2);
      tick();
      chk(tag, wb_dest, exp);
      chk({tag, "_cnt"}, 32'(wb_retired), 32'(cnt));
   endtask

   initial begin
      rst = 1'b1;
      wb_stall = 1'b0;
      wb_flush = 1'b0;
      set_mem(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
      tick();
      rst = 1'b0;

      // traffic, then reset held for two edges while MEM keeps offering work
      set_mem(1, 1, 0, 5'd5, 32'hCAFE_0001, 0, 2'b10, 0, 0, 4'h7, 4'h9);
      tick();
      tick();
      chk("pre_rst_cnt", 32'(wb_retired), 32'd2);
      rst = 1'b1;
      tick();
      tick();
      chk("rst_valid", 32'(wb_valid), 32'd0);
      chk("rst_wreg", 32'(wb_wreg), 32'd0);
      chk("rst_destR", 32'(wb_destR), 32'd0);
      chk("rst_dest", wb_dest, 32'd0);
      chk("rst_type", 32'(WB_ins_type), 32'd0);
      chk("rst_num", 32'(WB_ins_number), 32'd0);
      chk("rst_cnt", 32'(wb_retired), 32'd0);
      rst = 1'b0;

      // ALU pass-through
      set_mem(1, 1, 0, 5'd3, 32'h1234_5678, 32'hFFFF_FFFF, 2'b00, 0, 2'd3, 4'hA, 4'h5);
      tick();
      chk("alu_valid", 32'(wb_valid), 32'd1);
      chk("alu_wreg", 32'(wb_wreg), 32'd1);
      chk("alu_destR", 32'(wb_destR), 32'd3);
      chk("alu_dest", wb_dest, 32'h1234_5678);
      chk("alu_type", 32'(WB_ins_type), 32'hA);
      chk("alu_num", 32'(WB_ins_number), 32'h5);
      chk("alu_cnt", 32'(wb_retired), 32'd1);

      // sub-word loads from 0x80FF_7F01
      load(2'b00, 0, 2'd3, 32'hFFFF_FF80, 8'd2, "lb_off3");
      load(2'b00, 1, 2'd2, 32'h0000_00FF, 8'd3, "lbu_off2");
      load(2'b01, 0, 2'd2, 32'hFFFF_80FF, 8'd4, "lh_off2");
      load(2'b01, 1, 2'd0, 32'h0000_7F01, 8'd5, "lhu_off0");
      load(2'b10, 0, 2'd0, 32'h80FF_7F01, 8'd6, "lw");
      load(2'b01, 0, 2'd3, 32'hFFFF_80FF, 8'd7, "lh_off3");
      load(2'b11, 1, 2'd1, 32'h80FF_7F01, 8'd8, "lw11_off1");
      load(2'b00, 0, 2'd0, 32'h0000_0001, 8'd9, "lb_off0");
      chk("load_wreg", 32'(wb_wreg), 32'd1);

      // R0 destination: no write, data still visible
      set_mem(1, 1, 0, 5'd0, 32'hDEAD_BEEF, 0, 2'b10, 0, 0, 4'h3, 4'h4);
      tick();
      chk("r0_wreg", 32'(wb_wreg), 32'd0);
      chk("r0_valid", 32'(wb_valid), 32'd1);
      chk("r0_dest", wb_dest, 32'hDEAD_BEEF);
      chk("r0_cnt", 32'(wb_retired), 32'd10);

      // invalid slot with wreg set must not write or count
      set_mem(0, 1, 0, 5'd3, 32'h0BAD_0BAD, 0, 2'b10, 0, 0, 4'h0, 4'h0);
      tick();
      chk("inv_wreg", 32'(wb_wreg), 32'd0);
      chk("inv_valid", 32'(wb_valid), 32'd0);
      chk("inv_cnt", 32'(wb_retired), 32'd10);

      // R0 again, then stall three edges with changing MEM inputs
      set_mem(1, 1, 0, 5'd0, 32'hDEAD_BEEF, 0, 2'b10, 0, 0, 4'h3, 4'h4);
      tick();
      chk("r0b_cnt", 32'(wb_retired), 32'd11);
      wb_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_mem(1, 1, 0, 5'(i + 9), 32'h1111_1111 * (i + 1), 0, 2'b10, 0, 0, 4'hF, 4'(i));
         tick();
         chk("stall_dest", wb_dest, 32'hDEAD_BEEF);
         chk("stall_destR", 32'(wb_destR), 32'd0);
         chk("stall_valid", 32'(wb_valid), 32'd1);
         chk("stall_type", 32'(WB_ins_type), 32'h3);
         chk("stall_cnt", 32'(wb_retired), 32'd11);
      end
      wb_stall = 1'b0;
      set_mem(1, 1, 0, 5'd9, 32'h55AA_55AA, 0, 2'b10, 0, 0, 4'h6, 4'h8);
      tick();
      chk("unstall_destR", 32'(wb_destR), 32'd9);
      chk("unstall_dest", wb_dest, 32'h55AA_55AA);
      chk("unstall_wreg", 32'(wb_wreg), 32'd1);
      chk("unstall_num", 32'(WB_ins_number), 32'h8);
      chk("unstall_cnt", 32'(wb_retired), 32'd12);

      // flush and stall together
      wb_flush = 1'b1;
      wb_stall = 1'b1;
      set_mem(1, 1, 1, 5'd4, 32'h7777_7777, 0, 2'b10, 0, 0, 4'hC, 4'hD);
      tick();
      chk("flush_valid", 32'(wb_valid), 32'd0);
      chk("flush_wreg", 32'(wb_wreg), 32'd0);
      chk("flush_destR", 32'(wb_destR), 32'd0);
      chk("flush_type", 32'(WB_ins_type), 32'd0);
      chk("flush_cnt", 32'(wb_retired), 32'd12);
      wb_flush = 1'b0;

      // reset during a stall wins; next edge captures normally
      rst = 1'b1;
      tick();
      chk("rst_stall_cnt", 32'(wb_retired), 32'd0);
      chk("rst_stall_valid", 32'(wb_valid), 32'd0);
      rst = 1'b0;
      wb_stall = 1'b0;

      // counter wraps at 2^CNT_W
      for (int i = 0; i < 255; i++) tick();
      chk("cnt_max", 32'(wb_retired), 32'd255);
      chk("cnt_max_valid", 32'(wb_valid), 32'd1);
      chk("cnt_max_destR", 32'(wb_destR), 32'd4);
      tick();
      chk("cnt_wrap", 32'(wb_retired), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
